conv_frame_sequencer: RTL and testbench
=======================================

# conv_frame_sequencer

Raster sequencer placed directly in front of the 5x5 convolution datapath on the camera pixel stream. It forwards pixels through a one-stage register slice and tracks column and row within a WIDTH x HEIGHT frame. Each output beat carries frame-start, frame-end and window-valid flags. The block also owns kernel selection and switches it only on frame boundaries, so a frame is never convolved with a mix of kernels.

## Interface
Parameters:
- W, 30: pixel word width (10-bit R,G,B packed).
- WIDTH, 320: pixels per row.
- HEIGHT, 240: rows per frame.
- K, 5: kernel size; window is KxK.
- NKERN, 4: number of selectable kernels.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- x  dstream.in  W  pixel stream in (data/valid/ready).
- y  dstream.out  W  registered pixel stream out to the datapath.
- kern_req  in  1  one-cycle request to change kernel.
- kern_sel_req  in  $clog2(NKERN)  requested kernel index, sampled when kern_req=1.
- kern_sel  out  $clog2(NKERN)  active kernel index for the beat on y.
- kern_ack  out  1  one-cycle pulse, aligned to the beat on which a new kern_sel takes effect.
- col  out  $clog2(WIDTH)  column of the beat on y.
- row  out  $clog2(HEIGHT)  row of the beat on y.
- sof  out  1  beat on y is pixel (0,0).
- eof  out  1  beat on y is pixel (WIDTH-1,HEIGHT-1).
- win_valid  out  1  KxK window ending at this beat lies fully inside the frame.
- frame_count  out  16  frames completed (see Configuration).

## Operation
- Transfer: a pixel transfers when x.valid & x.ready. x.ready = y.ready, so the block adds no backpressure of its own.
- Internal position counters (cur_col, cur_row) hold the position of the next input pixel.
- On each transfer:
  - cur_col increments.
  - At WIDTH-1, cur_col wraps to 0 and cur_row increments.
  - At (WIDTH-1,HEIGHT-1), both wrap to 0.
- FSM:
  - IDLE: after reset. Moves to FILL on the first transfer.
  - FILL: input row < K-1. Moves to RUN when a transfer moves cur_row to K-1.
  - RUN: moves to FILL on the transfer of the eof pixel.
- win_valid = (row >= K-1) && (col >= K-1). It is never set in IDLE or FILL beats.
- Kernel switching:
  - kern_req latches kern_sel_req into a pending register and sets the pending flag. A later request overwrites an earlier one.
  - On the transfer of an sof pixel with the pending flag set, kern_sel takes the pending value, kern_ack is asserted on that beat and the pending flag clears.
  - If kern_req coincides with an sof transfer, the new request is applied on that same beat.
  - Without a pending request, kern_sel is unchanged and kern_ack = 0.
- Reset mid-frame:
  - All state returns to reset values and the pending request is discarded.
  - The next transfer is treated as sof (0,0).

## Timing
- Latency: 1 cycle from x transfer to y.valid / y.data.
- All sideband outputs (col, row, sof, eof, win_valid, kern_sel, kern_ack) are registered together with y.data.
- When y.ready=1:
  - y.valid <= x.valid.
  - y.data and the sideband outputs load only on a transfer.
- When y.ready=0: y and all sideband outputs hold their values.
- kern_ack is a single-cycle pulse. It is forced to 0 on the cycle after any accepted beat that carried it.
- Reset values:
  - y.valid=0, y.data=0.
  - col=0, row=0, sof=0, eof=0, win_valid=0.
  - kern_sel=0, kern_ack=0, frame_count=0.
  - State IDLE, pending flag clear.
- Width rules:
  - Counters are exact-width, with wrap at WIDTH-1 / HEIGHT-1, not at the power of two.
  - frame_count wraps modulo 2^16.

## Configuration
- CONV_FRAME_COUNT_EN defined: frame_count increments by 1 on the cycle the eof beat loads into y.
- CONV_FRAME_COUNT_EN undefined: frame_count is tied to 0 and no counter logic is synthesised.

## Test plan
- Reset, then one continuous 320x240 frame with y.ready=1:
  - first y.valid 1 cycle after first transfer, with sof=1, col=0, row=0;
  - first win_valid at beat index 1284 (row 4, col 4);
  - eof at beat 76799;
  - exactly 74576 win_valid beats.
- Backpressure: y.ready=0 for 3 cycles at col 150, row 10:
  - y and sideband held;
  - counters frozen;
  - output sequence identical to the no-stall run, with no lost or duplicated pixel.
- kern_req with sel=2 at beat 1000 of frame 0:
  - kern_sel stays 0 through eof of frame 0;
  - the sof beat of frame 1 shows kern_sel=2 and kern_ack=1;
  - exactly one ack.
- kern_req sel=1 at beat 500, then sel=3 at beat 600, of frame 0:
  - frame 1 sof shows kern_sel=3;
  - kern_sel never shows 1;
  - one ack.
- reset asserted at row 100 with a request pending:
  - all outputs return to reset values;
  - next transfer produces sof with row=0, col=0, kern_sel=0, kern_ack=0.
- CONV_FRAME_COUNT_EN defined, three frames streamed: frame_count steps 0→1→2→3, each step on the cycle the eof beat loads into y. Undefined: frame_count stays 0.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: one-stage register slice in front of the 5x5 convolution
// datapath. It tracks raster position, tags each output beat with frame-start,
// frame-end and window-valid flags, and switches the active kernel only on
// frame boundaries.
// Optional feature: define CONV_FRAME_COUNT_EN to build the completed-frame
// counter; without it frame_count is tied to zero.
//
// Handshake: a beat moves on x when x_valid && x_ready, and on y when
// y_valid && y_ready. x_ready mirrors y_ready combinationally, so the slice
// adds no backpressure of its own. While y_ready is low, y and every sideband
// output hold their values; valid never drops while a beat waits on y.
module conv_frame_sequencer #(
    parameter int W      = 30,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int K      = 5,
    parameter int NKERN  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [W-1:0]              x_data,
    input  logic                      x_valid,
    output logic                      x_ready,
    output logic [W-1:0]              y_data,
    output logic                      y_valid,
    input  logic                      y_ready,
    input  logic                      kern_req,
    input  logic [$clog2(NKERN)-1:0]  kern_sel_req,
    output logic [$clog2(NKERN)-1:0]  kern_sel,
    output logic                      kern_ack,
    output logic [$clog2(WIDTH)-1:0]  col,
    output logic [$clog2(HEIGHT)-1:0] row,
    output logic                      sof,
    output logic                      eof,
    output logic                      win_valid,
    output logic [15:0]               frame_count,
    output logic [1:0]                fsm_state
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int SW = $clog2(NKERN);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] next_col;
    logic [RW-1:0] next_row;
    logic          xfer;
    logic          at_eol;
    logic          at_eof;
    logic          at_sof;
    logic          in_window;
    logic          pend_valid;
    logic [SW-1:0] pend_sel;

    assign x_ready   = y_ready;
    assign fsm_state = state;

    // Position decode for the pixel currently offered on x
    always_comb begin
        xfer      = x_valid && y_ready;
        at_eol    = (cur_col == COL_LAST);
        at_eof    = at_eol && (cur_row == ROW_LAST);
        at_sof    = (cur_col == '0) && (cur_row == '0);
        next_col  = at_eol ? '0 : cur_col + CW'(1);
        next_row  = at_eof ? '0 : (at_eol ? cur_row + RW'(1) : cur_row);
        in_window = (state == RUN) && (cur_row >= ROW_KM1) && (cur_col >= COL_KM1);
    end

    // Register slice, raster counters and fill/run state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_col   <= '0;
            cur_row   <= '0;
            y_valid   <= 1'b0;
            y_data    <= '0;
            col       <= '0;
            row       <= '0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            win_valid <= 1'b0;
        end else if (y_ready) begin
            y_valid <= x_valid;
            if (x_valid) begin
                y_data    <= x_data;
                col       <= cur_col;
                row       <= cur_row;
                sof       <= at_sof;
                eof       <= at_eof;
                win_valid <= in_window;
                cur_col   <= next_col;
                cur_row   <= next_row;
                case (state)
                    IDLE:    state <= (at_eol && next_row == ROW_KM1) ? RUN : FILL;
                    FILL:    if (at_eol && next_row == ROW_KM1) state <= RUN;
                    RUN:     if (at_eof) state <= FILL;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Kernel selection: requests wait in a pending slot until the next sof transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_sel   <= '0;
            kern_sel   <= '0;
            kern_ack   <= 1'b0;
        end else if (xfer && at_sof && (kern_req || pend_valid)) begin
            kern_sel   <= kern_req ? kern_sel_req : pend_sel;
            kern_ack   <= 1'b1;
            pend_valid <= 1'b0;
        end else begin
            if (kern_req) begin
                pend_sel   <= kern_sel_req;
                pend_valid <= 1'b1;
            end
            // Any cycle where y advances retires a previous ack pulse
            if (y_ready) begin
                kern_ack <= 1'b0;
            end
        end
    end

`ifdef CONV_FRAME_COUNT_EN
    // Completed-frame counter, steps as the eof beat loads into y
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (xfer && at_eof) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on a reduced 10x7 frame with K=5.
// Honours CONV_FRAME_COUNT_EN for the frame_count expectations.
module tb_conv_frame_sequencer;

    localparam int W      = 30;
    localparam int WIDTH  = 10;
    localparam int HEIGHT = 7;
    localparam int K      = 5;
    localparam int NKERN  = 4;
    localparam int WH     = WIDTH * HEIGHT;

    logic          clk;
    logic          reset;
    logic [W-1:0]  x_data;
    logic          x_valid;
    logic          x_ready;
    logic [W-1:0]  y_data;
    logic          y_valid;
    logic          y_ready;
    logic          kern_req;
    logic [1:0]    kern_sel_req;
    logic [1:0]    kern_sel;
    logic          kern_ack;
    logic [3:0]    col;
    logic [2:0]    row;
    logic          sof;
    logic          eof;
    logic          win_valid;
    logic [15:0]   frame_count;
    logic [1:0]    fsm_state;

    int tests     = 0;
    int fails     = 0;
    int pix       = 0;
    int exp_kern  = 0;
    int fc_exp    = 0;
    int win_cnt   = 0;
    int first_win = -1;
    int eof_idx   = -1;
    int ack_cnt   = 0;

    conv_frame_sequencer #(
        .W(W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .K(K), .NKERN(NKERN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .x_data(x_data),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .y_data(y_data),
        .y_valid(y_valid),
        .y_ready(y_ready),
        .kern_req(kern_req),
        .kern_sel_req(kern_sel_req),
        .kern_sel(kern_sel),
        .kern_ack(kern_ack),
        .col(col),
        .row(row),
        .sof(sof),
        .eof(eof),
        .win_valid(win_valid),
        .frame_count(frame_count),
        .fsm_state(fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(input int p);
        return W'((p * 1103) ^ 32'h15A5_A5A5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at pix %0d: observed %0h expected %0h", tag, pix, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_data", 32'(y_data), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_sof", 32'(sof), 32'd0);
        chk("rst_eof", 32'(eof), 32'd0);
        chk("rst_win", 32'(win_valid), 32'd0);
        chk("rst_kern_sel", 32'(kern_sel), 32'd0);
        chk("rst_kern_ack", 32'(kern_ack), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_fsm", 32'(fsm_state), 32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        x_valid  = 1'b1;
        x_data   = '1;
        y_ready  = 1'b1;
        kern_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        x_valid = 1'b0;
        pix      = 0;
        exp_kern = 0;
        fc_exp   = 0;
    endtask

    // One transfer through the slice, checking the resulting beat on y
    task automatic send(input logic req, input logic [1:0] sel, input logic exp_ack);
        int fl, c, r, st;
        logic exp_eof;
        fl = pix % WH;
        c  = fl % WIDTH;
        r  = fl / WIDTH;
        exp_eof = (fl == WH - 1);
        st = (fl + 1 == WH) ? 1 : (((fl + 1) / WIDTH < K - 1) ? 1 : 2);
        y_ready      = 1'b1;
        x_valid      = 1'b1;
        x_data       = pat(pix);
        kern_req     = req;
        kern_sel_req = sel;
        @(posedge clk);
        #1;
        x_valid  = 1'b0;
        kern_req = 1'b0;
`ifdef CONV_FRAME_COUNT_EN
        if (exp_eof) fc_exp++;
`endif
        chk("y_valid", 32'(y_valid), 32'd1);
        chk("y_data", 32'(y_data), 32'(pat(pix)));
        chk("col", 32'(col), 32'(c));
        chk("row", 32'(row), 32'(r));
        chk("sof", 32'(sof), 32'(fl == 0));
        chk("eof", 32'(eof), 32'(exp_eof));
        chk("win_valid", 32'(win_valid), 32'(r >= K - 1 && c >= K - 1));
        chk("kern_sel", 32'(kern_sel), 32'(exp_kern));
        chk("kern_ack", 32'(kern_ack), 32'(exp_ack));
        chk("fsm_state", 32'(fsm_state), 32'(st));
        chk("frame_count", 32'(frame_count), 32'(fc_exp));
        if (win_valid === 1'b1) begin
            win_cnt++;
            if (first_win < 0) first_win = fl;
        end
        if (eof === 1'b1) eof_idx = fl;
        if (kern_ack === 1'b1) ack_cnt++;
        pix++;
    endtask

    // y_ready low with a pixel offered: nothing moves, everything holds
    task automatic stall(input int n);
        int fl;
        fl = (pix - 1) % WH;
        y_ready = 1'b0;
        x_valid = 1'b1;
        x_data  = ~pat(pix);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("stall_x_ready", 32'(x_ready), 32'd0);
            chk("stall_y_valid", 32'(y_valid), 32'd1);
            chk("stall_y_data", 32'(y_data), 32'(pat(pix - 1)));
            chk("stall_col", 32'(col), 32'(fl % WIDTH));
            chk("stall_row", 32'(row), 32'(fl / WIDTH));
            chk("stall_kern_ack", 32'(kern_ack), 32'd0);
        end
        x_valid = 1'b0;
        y_ready = 1'b1;
    endtask

    // Bubble on x with y_ready high: y_valid drops, data holds
    task automatic bubble(input int n);
        y_ready = 1'b1;
        x_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("bubble_y_valid", 32'(y_valid), 32'd0);
            chk("bubble_y_data", 32'(y_data), 32'(pat(pix - 1)));
            chk("bubble_kern_ack", 32'(kern_ack), 32'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        x_data       = '0;
        x_valid      = 1'b0;
        y_ready      = 1'b1;
        kern_req     = 1'b0;
        kern_sel_req = '0;

        // reset state and ready pass-through
        do_reset();
        check_reset_state();
        y_ready = 1'b0;
        #1;
        chk("x_ready_low", 32'(x_ready), 32'd0);
        y_ready = 1'b1;
        #1;
        chk("x_ready_high", 32'(x_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("idle_y_valid", 32'(y_valid), 32'd0);
        chk("idle_fsm", 32'(fsm_state), 32'd0);

        // frame 0: request kernel 2 at beat 10, must not take effect this frame
        win_cnt = 0; first_win = -1; eof_idx = -1;
        for (int b = 0; b < WH; b++) send(b == 10, 2'd2, 1'b0);
        chk("first_win_beat", 32'(first_win), 32'd44);
        chk("win_count", 32'(win_cnt), 32'd18);
        chk("eof_beat", 32'(eof_idx), 32'd69);

        // frame 1: kernel 2 lands on sof; requests 1 then 3; stall and bubble
        exp_kern = 2;
        send(1'b0, 2'd0, 1'b1);
        for (int b = 1; b < WH; b++) begin
            if (b == 35) stall(3);
            if (b == 50) bubble(2);
            send(b == 5 || b == 6, (b == 5) ? 2'd1 : 2'd3, 1'b0);
        end

        // frame 2: only the later request (3) is applied
        exp_kern = 3;
        send(1'b0, 2'd0, 1'b1);
        for (int b = 1; b < WH; b++) send(1'b0, 2'd0, 1'b0);
`ifdef CONV_FRAME_COUNT_EN
        chk("frame_count_3", 32'(frame_count), 32'd3);
`else
        chk("frame_count_off", 32'(frame_count), 32'd0);
`endif
        chk("ack_count_3frames", 32'(ack_cnt), 32'd2);

        // frame 3: request coinciding with sof applies on that beat
        exp_kern = 1;
        send(1'b1, 2'd1, 1'b1);
        for (int b = 1; b < 55; b++) send(b == 20, 2'd2, 1'b0);

        // reset at row 5 with kernel 2 pending: discarded
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pix = 0; exp_kern = 0; fc_exp = 0;
        check_reset_state();
        for (int b = 0; b < WH + 1; b++) send(1'b0, 2'd0, 1'b0);
        chk("ack_count_total", 32'(ack_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
